// File: rtl/nn_loader_pkg.sv
// Shared definitions for nn_input_loader: FSM states, default frame geometry
// and the pixel-to-fixed-point conversion used when writing frame elements.
package nn_loader_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_INPUTS = 784;
  localparam int PIX_WIDTH  = 8;
  localparam int IDX_WIDTH  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } loader_state_e;

  // Drops the pixel LSB so the element lands in 0x0000..0x007F.
  function automatic logic [DATA_WIDTH-1:0] pix_to_fixed(input logic [PIX_WIDTH-1:0] pix);
    return DATA_WIDTH'(pix >> 1);
  endfunction

endpackage

// File: rtl/nn_input_loader.sv
// Streams pixels into the NeuralNetwork input vector NNin and holds it until nn_done.
// Optional: define NN_LOADER_LAST_CHECK_EN to cross-check pix_last against the count (frame_err).
module nn_input_loader
  import nn_loader_pkg::*;
#(
  parameter int dataWidth = DATA_WIDTH,
  parameter int numInputs = NUM_INPUTS,
  parameter int pixWidth  = PIX_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [pixWidth-1:0]            pix_in,
  input  logic                           pix_valid,
  input  logic                           pix_last,
  output logic                           pix_ready,
  input  logic                           nn_done,
  output logic [numInputs*dataWidth-1:0] NNin,
  output logic                           NNvalid,
  output logic                           frame_err
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(numInputs - 1);

  loader_state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]           idx_q, idx_d;
  logic [numInputs*dataWidth-1:0] nn_in_q, nn_in_d;
  logic                           accept;
  logic                           at_last;
  logic                           bad_frame;
  logic [dataWidth-1:0]           pix_elem;

  assign pix_ready = (state_q == ST_LOAD);
  assign NNvalid   = (state_q == ST_HOLD);
  assign NNin      = nn_in_q;
  assign accept    = pix_valid && pix_ready;
  assign at_last   = (idx_q == LAST_IDX);
  assign pix_elem  = dataWidth'(pix_to_fixed(PIX_WIDTH'(pix_in)));

`ifdef NN_LOADER_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;

  // A frame is malformed when pix_last and the final count position disagree.
  assign bad_frame   = accept && (pix_last != at_last);
  assign frame_err_d = bad_frame;
  assign frame_err   = frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
`else
  logic unused_pix_last;

  assign unused_pix_last = pix_last;
  assign bad_frame       = 1'b0;
  assign frame_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nn_in_d = nn_in_q;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          nn_in_d[int'(idx_q)*dataWidth +: dataWidth] = pix_elem;
          // Old elements stay in place; only NNvalid says the frame is complete.
          if (bad_frame) begin
            idx_d = '0;
          end else if (at_last) begin
            idx_d   = '0;
            state_d = ST_HOLD;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      ST_HOLD: begin
        if (nn_done) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      nn_in_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nn_in_q <= nn_in_d;
    end
  end

endmodule

// File: tb/tb_nn_input_loader.sv
// Randomized scoreboard bench for nn_input_loader: a frame model predicts the
// held NNin contents, NNvalid rise cycle and frame_err pulses; a monitor compares.
`timescale 1ns/1ps
module tb_nn_input_loader;

  localparam int DW = 16;
  localparam int NI = 784;

`ifdef NN_LOADER_LAST_CHECK_EN
  localparam bit LAST_CHECK = 1'b1;
`else
  localparam bit LAST_CHECK = 1'b0;
`endif

  typedef logic [NI*DW-1:0] frame_t;
  typedef struct {
    frame_t frame;
    int     cycle;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_last;
  logic       pix_ready;
  logic       nn_done;
  frame_t     NNin;
  logic       NNvalid;
  logic       frame_err;

  nn_input_loader #(
    .dataWidth(DW),
    .numInputs(NI),
    .pixWidth (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_last (pix_last),
    .pix_ready(pix_ready),
    .nn_done  (nn_done),
    .NNin     (NNin),
    .NNvalid  (NNvalid),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  int checkCount = 0;
  int passCount  = 0;

  logic [DW-1:0] modelMem [NI];
  int            modelIdx;
  bit            modelHold;
  bit            stalled = 1'b0;
  exp_t          expQ[$];
  int            errQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
  endtask

  task automatic checkFrame(input string name, input frame_t actual, input frame_t expected);
    int firstBad;
    firstBad = 0;
    checkCount++;
    if (actual === expected) passCount++;
    else begin
      for (int i = NI - 1; i >= 0; i--)
        if (actual[i*DW +: DW] !== expected[i*DW +: DW]) firstBad = i;
      $display("[TB] FAIL %s: element %0d is 0x%h, expected 0x%h (cycle %0d)", name, firstBad,
               actual[firstBad*DW +: DW], expected[firstBad*DW +: DW], cycleCount);
    end
  endtask

  function automatic frame_t modelFrame();
    frame_t f;
    for (int i = 0; i < NI; i++) f[i*DW +: DW] = modelMem[i];
    return f;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NI; i++) modelMem[i] = '0;
    modelIdx  = 0;
    modelHold = 1'b0;
  endtask

  // Offers one pixel after an idle gap; the model is updated when the handshake is seen.
  task automatic applyStimulus(input logic [7:0] p, input bit last, input int gap, input bit doneWhileLoading);
    int   waited;
    bit   accepted;
    exp_t e;
    if (stalled) return;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    pix_in    = p;
    pix_valid = 1'b1;
    pix_last  = last;
    nn_done   = doneWhileLoading;
    waited    = 0;
    accepted  = 1'b0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (pix_ready === 1'b1) accepted = 1'b1;
      else begin waited++; @(posedge clk); #1; end
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 32'(waited), 0);
      stalled = 1'b1;
    end else begin
      modelMem[modelIdx] = 16'(p) / 16'd2;
      if (LAST_CHECK && (last != (modelIdx == NI - 1))) begin
        errQ.push_back(cycleCount + 1);
        modelIdx = 0;
      end else if (modelIdx == NI - 1) begin
        e.frame = modelFrame();
        e.cycle = cycleCount + 1;
        expQ.push_back(e);
        modelIdx  = 0;
        modelHold = 1'b1;
      end else begin
        modelIdx++;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    nn_done   = 1'b0;
  endtask

  task automatic sendFrame(input int pattern, input int gapMax, input int badLastAt, input int count);
    logic [7:0] p;
    int         gap;
    for (int k = 0; k < count; k++) begin
      case (pattern)
        0:       p = 8'hFF;
        1:       p = 8'(k % 256);
        default: p = 8'($urandom_range(255, 0));
      endcase
      gap = (gapMax == 0) ? 0 : int'($urandom_range(gapMax, 0));
      applyStimulus(p, (k == NI - 1) || (k == badLastAt), gap, (pattern == 2) && (k % 50 == 7));
    end
  endtask

  // Hammers pix_valid while the frame is held, then releases it with nn_done.
  task automatic holdAndRelease();
    int waited;
    int holdAccepts;
    waited = 0;
    while (NNvalid !== 1'b1 && waited < 5) begin @(posedge clk); #1; waited++; end
    checkOutput("hold_entry", 32'(NNvalid), 1);
    holdAccepts = 0;
    for (int i = 0; i < 50; i++) begin
      pix_in    = 8'($urandom_range(255, 0));
      pix_valid = 1'b1;
      pix_last  = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      if (pix_ready !== 1'b0) holdAccepts++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    checkOutput("hold_accepts", 32'(holdAccepts), 0);
    checkFrame("hold_frozen", NNin, modelFrame());
    checkOutput("hold_valid_level", 32'(NNvalid), 1);
    nn_done = 1'b1;
    @(posedge clk); #1;
    nn_done   = 1'b0;
    modelHold = 1'b0;
    @(negedge clk);
    checkOutput("valid_after_done", 32'(NNvalid), 0);
    checkOutput("ready_after_done", 32'(pix_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic checkResetState(input string tag);
    checkFrame({tag, "_nnin"}, NNin, '0);
    checkOutput({tag, "_nnvalid"}, 32'(NNvalid), 0);
    checkOutput({tag, "_ready"}, 32'(pix_ready), 0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  // nn_done is pulsed during IDLE to show it cannot divert the IDLE->LOAD step.
  task automatic releaseReset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_not_ready", 32'(pix_ready), 0);
    nn_done = 1'b1;
    @(posedge clk); #1;
    nn_done = 1'b0;
    @(negedge clk);
    checkOutput("load_after_idle", 32'(pix_ready), 1);
    @(posedge clk); #1;
  endtask

  exp_t monExp;
  logic prevValid   = 1'b0;
  int   acceptCount = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        acceptCount = 0;
        prevValid   = 1'b0;
      end else begin
        if (NNvalid === 1'b1 && !prevValid) begin
          checkOutput("frame_pending", 32'(expQ.size()), 1);
          if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkFrame("frame_data", NNin, monExp.frame);
            checkOutput("valid_cycle", 32'(cycleCount), 32'(monExp.cycle));
            checkOutput("accepts_per_frame", 32'(acceptCount), NI);
            checkOutput("ready_in_hold", 32'(pix_ready), 0);
          end
          acceptCount = 0;
        end
        if (frame_err !== 1'b0) begin
          checkOutput("err_pending", 32'(errQ.size()), 1);
          if (errQ.size() > 0) checkOutput("err_cycle", 32'(cycleCount), 32'(errQ.pop_front()));
          acceptCount = 0;
        end
        if (pix_valid === 1'b1 && pix_ready === 1'b1) acceptCount++;
        prevValid = (NNvalid === 1'b1);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    nn_done   = 1'b0;
    clearModel();
    @(posedge clk); #1;
    checkResetState("por");
    releaseReset();

    $display("[TB] frame of 0xFF pixels, back-to-back");
    sendFrame(0, 0, -1, NI);
    checkFrame("all_elements_7f", NNin, {NI{16'h007F}});
    holdAndRelease();

    $display("[TB] ramp frame k mod 256 with random gaps");
    sendFrame(1, 3, -1, NI);
    checkOutput("elem300", 32'(NNin[300*DW +: DW]), 32'h16);
    checkOutput("elem255", 32'(NNin[255*DW +: DW]), 32'h7F);
    holdAndRelease();

    $display("[TB] random frame with pix_last on pixel 100");
    sendFrame(2, 0, 100, NI);
    if (!modelHold) sendFrame(2, 1, -1, NI);
    holdAndRelease();

    $display("[TB] partial frame, then reset at pixel 400");
    sendFrame(2, 1, -1, 10);
    checkFrame("partial_keeps_old", NNin, modelFrame());
    sendFrame(1, 1, -1, 390);
    reset = 1'b1;
    #1;
    clearModel();
    checkResetState("midload");
    releaseReset();

    $display("[TB] full random frame after reset");
    sendFrame(2, 2, -1, NI);
    holdAndRelease();

    repeat (5) @(posedge clk);
    checkOutput("frames_drained", 32'(expQ.size()), 0);
    checkOutput("errs_drained", 32'(errQ.size()), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nn_input_loader.md
NN_INPUT_LOADER -- requirements
Module: nn_input_loader

Interface
REQ-001 Parameter dataWidth, 16, width of one NNin element.
REQ-002 Parameter numInputs, 784, elements per frame.
REQ-003 Parameter pixWidth, 8, width of one incoming pixel.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_in  input  pixWidth  unsigned pixel byte.
REQ-007 pix_valid  input  1  pix_in valid this cycle.
REQ-008 pix_last  input  1  marks final pixel of a frame.
REQ-009 pix_ready  output  1  loader accepts a pixel this cycle.
REQ-010 nn_done  input  1  single-cycle completion pulse from the network (its maxValid).
REQ-011 NNin  output  numInputs*dataWidth  assembled frame, element k at bits [k*dataWidth +: dataWidth].
REQ-012 NNvalid  output  1  NNin complete and stable.
REQ-013 frame_err  output  1  one-cycle framing-error pulse.

Function
REQ-014 FSM states IDLE, LOAD, HOLD; IDLE->LOAD unconditionally on the cycle after reset release.
REQ-015 Handshake: pixel accepted on a cycle where pix_valid=1 and pix_ready=1; pix_ready=1 only in LOAD, decoded from registered state, with no combinational path from pix_valid.
REQ-016 Index counter idx, 0..numInputs-1, 10 bits; the accepted pixel is written to element idx, then idx increments.
REQ-017 Conversion: element = zero-extended {1'b0, pix_in[7:1]}, giving range 0x0000..0x007F.
REQ-018 Acceptance at idx=numInputs-1 moves to HOLD and resets idx to 0; NNvalid rises the next cycle.
REQ-019 In HOLD: NNvalid=1 (level), pix_ready=0, NNin frozen.
REQ-020 nn_done=1 in HOLD -> LOAD next cycle; NNvalid falls that same cycle; NNin retains old frame contents until overwritten element by element.
REQ-021 nn_done is ignored in IDLE and LOAD.
REQ-022 pix_valid without pix_ready produces no state change; the upstream source holds its data.
REQ-023 Elements not yet overwritten in a new frame keep their previous-frame values; only NNvalid qualifies NNin.

Reset
REQ-024 On reset assertion, immediately: state=IDLE, idx=0, NNin=0, NNvalid=0, pix_ready=0, frame_err=0.
REQ-025 Reset mid-LOAD or mid-HOLD discards the partial or held frame; no frame_err is raised.

Configuration
REQ-026 Macro NN_LOADER_LAST_CHECK_EN.
REQ-027 Defined: accepted pix_last=1 with idx<numInputs-1 -> frame_err pulse, idx=0, stay LOAD, no HOLD entry.
REQ-028 Defined: accepted pixel at idx=numInputs-1 with pix_last=0 -> frame_err pulse, idx=0, stay LOAD, no HOLD entry.
REQ-029 Defined: frame_err is registered and asserts the cycle after the offending acceptance.
REQ-030 Undefined: pix_last is ignored, frame_err is tied to 0, and the frame ends purely on count.

Structure
REQ-031 Package nn_loader_pkg holds the state enum, default dataWidth/numInputs/pixWidth constants, and the pixel-to-fixed conversion function.
REQ-032 No sub-module; the FSM, counter and frame buffer live in nn_input_loader.
REQ-033 Instantiated directly ahead of NeuralNetwork: NNin/NNvalid drive it, and its maxValid drives nn_done.

Verification
REQ-034 Reset, then stream 784 pixels of 0xFF back-to-back with pix_last on the last -> every element 0x007F; NNvalid=1 one cycle after the 784th acceptance; pix_ready=0.
REQ-035 Pixel k = k mod 256 with random pix_valid gaps -> element k = (k mod 256)>>1 (element 300 = 0x0016); acceptance count = 784.
REQ-036 In HOLD, drive pix_valid=1 for 50 cycles, then pulse nn_done -> NNin unchanged and no acceptances during HOLD; LOAD and pix_ready=1 the cycle after nn_done; NNvalid=0.
REQ-037 With NN_LOADER_LAST_CHECK_EN: pix_last on pixel 100 -> frame_err pulse, idx=0; a following correct 784-pixel frame -> NNvalid=1.
REQ-038 Assert reset at pixel 400, release, send a full frame -> NNvalid only after 784 new acceptances; frame_err stays 0.
REQ-039 End-to-end: load stored frame 7 into loader feeding NeuralNetwork -> maxValid then NNvalid falls; maxIndex matches the golden label.
